// File: rtl/key_command_queue_pkg.sv
// Shared game package: keyboard command width and command encodings.
// Keyboard_Decoder produces these codes, key_command_queue buffers them,
// and Game_Player consumes them.
package key_command_queue_pkg;

    // Width of one keyboard command code.
    localparam int CMD_W = 3;

    // Command encodings carried on in_data/out_data.
    typedef enum logic [CMD_W-1:0] {
        CMD_NONE   = 3'd0,
        CMD_UP     = 3'd1,
        CMD_DOWN   = 3'd2,
        CMD_LEFT   = 3'd3,
        CMD_RIGHT  = 3'd4,
        CMD_SELECT = 3'd5,
        CMD_SWITCH = 3'd6
    } cmd_e;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single level signal crossing into the
// clock domain.
// Ports:
//   clock - destination clock
//   reset - synchronous, active-high; clears every stage
//   d     - asynchronous level input
//   q     - synchronized level, STAGES clock edges behind d
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift left so the input enters at bit 0; this form also works for STAGES=1.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d);
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/key_command_queue.sv
// Keyboard command queue between Keyboard_Decoder (clk_100m domain) and
// Game_Player (clk_50M domain). Each upstream ready episode is captured once
// and acknowledged with a one-cycle in_read_fin pulse. Captured commands are
// buffered in a small circular queue and popped on the rising edge of
// out_read_fin.
// Ports:
//   clock        - game logic clock; all state updates on the rising edge
//   reset        - synchronous, active-high
//   in_ready     - new-data level from the decoder (asynchronous)
//   in_data      - command code, stable while in_ready is high
//   in_read_fin  - one-cycle acknowledge of a capture
//   flush        - discard every queued command and clear overflow
//   out_ready    - queue non-empty, head is valid on out_data
//   out_data     - head-of-queue command
//   out_read_fin - consumer done with head; its rising edge pops
//   count        - current occupancy (0..DEPTH)
//   overflow     - sticky, a command was dropped because the queue was full
module key_command_queue
    import key_command_queue_pkg::*;
#(
    parameter int DATA_WIDTH  = CMD_W,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_read_fin,
    input  logic                     flush,
    output logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    input  logic                     out_read_fin,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  in_ready_s;
    logic                  armed;
    logic                  read_fin_prev;
    logic                  capture;
    logic                  pop;
    logic                  push;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_ready_sync (
        .clock (clock),
        .reset (reset),
        .d     (in_ready),
        .q     (in_ready_s)
    );

    // A capture is taken once per ready episode; armed re-opens only after
    // the synchronized ready has been seen low. A pop is the rising edge of
    // out_read_fin on a non-empty queue. When full, a coincident pop frees
    // the slot the capture needs, so nothing is dropped.
    always_comb begin
        capture = in_ready_s & armed;
        pop     = out_read_fin & ~read_fin_prev & (count != '0);
        push    = capture & ~flush & ((count != FULL_COUNT) | pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            armed         <= 1'b1;
            in_read_fin   <= 1'b0;
            read_fin_prev <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow      <= 1'b0;
        end else begin
            in_read_fin   <= capture;
            read_fin_prev <= out_read_fin;

            if (capture) begin
                armed <= 1'b0;
            end else if (!in_ready_s) begin
                armed <= 1'b1;
            end

            if (flush) begin
                // Flush wins over a simultaneous capture or pop; the capture
                // is still acknowledged above but its data is discarded.
                count    <= '0;
                rd_ptr   <= wr_ptr;
                overflow <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
                if (capture && !push) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; out_data is meaningless while out_ready is low.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign out_data  = mem[rd_ptr];
    assign out_ready = (count != '0);

endmodule

// File: tb/tb_key_command_queue.sv
module tb_key_command_queue;

    localparam int DW    = 3;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_read_fin;
    logic          flush;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_read_fin;
    logic [CW-1:0] count;
    logic          overflow;

    key_command_queue #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_read_fin  (in_read_fin),
        .flush        (flush),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_read_fin (out_read_fin),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue contents held as an SV queue, the synchronizer
    // as a history of raw in_ready samples, and an episode flag that tells
    // whether the current synchronized-high episode has been acknowledged.
    bit            ready_hist [SS];
    bit            episode_open;
    bit            m_prev_fin;
    bit            m_ack;
    bit            m_ovf;
    logic [DW-1:0] mq [$];

    typedef struct {
        bit            rdy;
        logic [DW-1:0] d;
        bit            fl;
        bit            ori;
        bit            e_or;
        logic [CW-1:0] e_cnt;
        bit            e_ovf;
        bit            e_irf;
        logic [DW-1:0] e_d;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(int rdy, int d, int fl, int ori,
                                int e_or, int e_cnt, int e_ovf, int e_irf, int e_d);
        vec_t v;
        v.rdy   = rdy[0];
        v.d     = DW'(d);
        v.fl    = fl[0];
        v.ori   = ori[0];
        v.e_or  = e_or[0];
        v.e_cnt = CW'(e_cnt);
        v.e_ovf = e_ovf[0];
        v.e_irf = e_irf[0];
        v.e_d   = DW'(e_d);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge: inputs are those driven before the edge; the model
    // advances with them, and outputs are sampled 1 time unit later.
    task automatic step();
        bit            r   = reset;
        bit            ir  = in_ready;
        bit            fl  = flush;
        bit            ori = out_read_fin;
        logic [DW-1:0] d   = in_data;
        bit            rs;
        bit            cap;
        bit            pp;
        @(posedge clock);
        #1;
        if (r) begin
            for (int i = 0; i < SS; i++) ready_hist[i] = 1'b0;
            episode_open = 1'b1;
            m_prev_fin   = 1'b0;
            m_ack        = 1'b0;
            m_ovf        = 1'b0;
            mq.delete();
        end else begin
            rs = ready_hist[SS-1];
            for (int i = SS-1; i > 0; i--) ready_hist[i] = ready_hist[i-1];
            ready_hist[0] = ir;
            cap = rs && episode_open;
            pp  = ori && !m_prev_fin && (mq.size() > 0);
            if (fl) begin
                mq.delete();
                m_ovf = 1'b0;
            end else begin
                if (pp) void'(mq.pop_front());
                if (cap) begin
                    if (mq.size() < DEPTH) mq.push_back(d);
                    else m_ovf = 1'b1;
                end
            end
            m_ack      = cap;
            m_prev_fin = ori;
            if (cap) episode_open = 1'b0;
            else if (!rs) episode_open = 1'b1;
        end
    endtask

    task automatic model_check(input string tag);
        logic [5:0] exp_s;
        exp_s = {mq.size() != 0, CW'(mq.size()), m_ovf, m_ack};
        check({tag, ".status"}, {26'd0, out_ready, count, overflow, in_read_fin}, {26'd0, exp_s});
        if (mq.size() != 0) check({tag, ".data"}, 32'(out_data), 32'(mq[0]));
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        in_ready     = 1'b0;
        in_data      = '0;
        flush        = 1'b0;
        out_read_fin = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push(input int d);
        bit got = 1'b0;
        in_ready = 1'b1;
        in_data  = DW'(d);
        for (int k = 0; k < 12 && !got; k++) begin
            step();
            if (in_read_fin) got = 1'b1;
        end
        check("push_ack", 32'(got), 32'd1);
        in_ready = 1'b0;
        repeat (SS + 1) step();
    endtask

    task automatic pop_one();
        out_read_fin = 1'b1;
        step();
        out_read_fin = 1'b0;
        step();
    endtask

    initial begin
        int pulses;

        // Table: single command, then flush coinciding with a capture.
        tbl.push_back(mk(1,2,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,2,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,2,0,0, 1,1,0,1,2));
        tbl.push_back(mk(0,0,0,0, 1,1,0,0,2));
        tbl.push_back(mk(0,0,0,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,5,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,5,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,5,0,0, 1,1,0,1,5));
        tbl.push_back(mk(0,0,0,0, 1,1,0,0,5));
        tbl.push_back(mk(0,0,0,0, 1,1,0,0,5));
        tbl.push_back(mk(1,6,0,0, 1,1,0,0,5));
        tbl.push_back(mk(1,6,0,0, 1,1,0,0,5));
        tbl.push_back(mk(1,6,1,0, 0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,0));

        do_reset();
        check("reset_state", {28'd0, out_ready, count}, 32'd0);
        check("reset_flags", {30'd0, overflow, in_read_fin}, 32'd0);
        for (int i = 0; i < tbl.size(); i++) begin
            in_ready     = tbl[i].rdy;
            in_data      = tbl[i].d;
            flush        = tbl[i].fl;
            out_read_fin = tbl[i].ori;
            step();
            check($sformatf("tbl[%0d].status", i),
                  {26'd0, out_ready, count, overflow, in_read_fin},
                  {26'd0, tbl[i].e_or, tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_irf});
            if (tbl[i].e_or) check($sformatf("tbl[%0d].data", i), 32'(out_data), 32'(tbl[i].e_d));
        end
        flush = 1'b0;

        // Fill and overflow, drain in order, then flush clears overflow.
        do_reset();
        for (int d = 1; d <= 5; d++) push(d);
        check("fill.count", 32'(count), 32'd4);
        check("fill.overflow", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain[%0d]", i), 32'(out_data), 32'(i));
            pop_one();
        end
        check("drain.count", 32'(count), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush.overflow", 32'(overflow), 32'd0);

        // Held acknowledge pops once.
        do_reset();
        for (int d = 1; d <= 3; d++) push(d);
        out_read_fin = 1'b1;
        repeat (10) step();
        check("held_ack.count", 32'(count), 32'd2);
        out_read_fin = 1'b0;
        step();

        // Simultaneous push and pop while full.
        do_reset();
        for (int d = 1; d <= 4; d++) push(d);
        in_ready = 1'b1;
        in_data  = 3'd7;
        step();
        step();
        out_read_fin = 1'b1;
        step();
        check("pushpop.ack", 32'(in_read_fin), 32'd1);
        check("pushpop.count", 32'(count), 32'd4);
        check("pushpop.overflow", 32'(overflow), 32'd0);
        out_read_fin = 1'b0;
        in_ready     = 1'b0;
        step();
        check("pushpop.order0", 32'(out_data), 32'd2);
        pop_one();
        check("pushpop.order1", 32'(out_data), 32'd3);
        pop_one();
        check("pushpop.order2", 32'(out_data), 32'd4);
        pop_one();
        check("pushpop.order3", 32'(out_data), 32'd7);

        // Long ready episode, then reset in the middle of it.
        do_reset();
        in_ready = 1'b1;
        in_data  = 3'd3;
        pulses   = 0;
        repeat (50) begin
            step();
            if (in_read_fin) pulses++;
        end
        check("long.pulses", 32'(pulses), 32'd1);
        check("long.count", 32'(count), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset.count", 32'(count), 32'd0);
        step();
        check("midreset.early", 32'(in_read_fin), 32'd0);
        step();
        step();
        check("midreset.ack", 32'(in_read_fin), 32'd1);
        check("midreset.count1", 32'(count), 32'd1);

        // Randomized traffic against the reference model.
        do_reset();
        model_check("rand_reset");
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3) == 0) begin
                in_ready = ~in_ready;
                if (in_ready) in_data = DW'($urandom);
            end
            flush = ($urandom_range(29) == 0);
            if (c < 400) out_read_fin = ($urandom_range(7) == 0);
            else         out_read_fin = ($urandom_range(1) == 0);
            step();
            model_check($sformatf("rand[%0d]", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
